// File: rtl/uart_word_tx_pkg.sv
// Shared definitions for the word-level UART transmitter: frame geometry,
// FSM state encoding and a counter-width helper.
package uart_word_tx_pkg;

  localparam int NB_BYTE   = 8;
  localparam int FRAME_LEN = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_word_tx_baud_tick.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. Reset and restart both return the count to zero.
module uart_baud_tick
  import uart_word_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CNT_W = width_min1(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // With CLKS_PER_BIT=1 the count is stuck at zero, so the tick is constant.
  assign o_tick = (cnt_r == LAST_CNT);

  // Bit-period counter with wrap on tick.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_r <= '0;
    end else if (i_restart || o_tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Word transmitter: serialises an NB_DATA-bit word as consecutive 8N1 frames,
// least-significant byte first, with a one-cycle done pulse per word.
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int NB_DATA      = 16,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_tx_start,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_busy
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int BYTE_W  = width_min1(N_BYTES);
  localparam logic [BYTE_W-1:0]  LAST_BYTE = BYTE_W'(N_BYTES - 1);
  localparam logic [NB_DATA-1:0] LOW_MASK  = NB_DATA'(8'hFF);

  state_t              state_r;
  logic [NB_DATA-1:0]  shift_r;
  logic [2:0]          bit_cnt_r;
  logic [BYTE_W-1:0]   byte_cnt_r;
  logic                tick_s;
  logic                restart_s;

  // Shift only the byte on the wire; upper bytes wait their turn untouched.
  function automatic logic [NB_DATA-1:0] shift_low_byte(input logic [NB_DATA-1:0] v);
    return (v & ~LOW_MASK) | ((v & LOW_MASK) >> 1);
  endfunction

  // Holding the divider clear in IDLE/DONE makes every frame start on a fresh period.
  assign restart_s = (state_r == ST_IDLE) || (state_r == ST_DONE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_restart (restart_s),
    .o_tick    (tick_s)
  );

  // Transmit FSM with registered line, busy and done outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      shift_r    <= '0;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= '0;
      o_tx       <= 1'b1;
      o_tx_done  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          o_tx_done <= 1'b0;
          if (i_tx_start) begin
            shift_r    <= i_data;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= '0;
            o_tx       <= 1'b0;
            o_busy     <= 1'b1;
            state_r    <= ST_START;
          end else begin
            o_tx   <= 1'b1;
            o_busy <= 1'b0;
          end
        end
        ST_START: begin
          if (tick_s) begin
            o_tx    <= shift_r[0];
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            shift_r   <= shift_low_byte(shift_r);
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              o_tx    <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              o_tx <= shift_r[1];
            end
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            if (byte_cnt_r != LAST_BYTE) begin
              byte_cnt_r <= byte_cnt_r + BYTE_W'(1);
              shift_r    <= shift_r >> NB_BYTE;
              bit_cnt_r  <= 3'd0;
              o_tx       <= 1'b0;
              state_r    <= ST_START;
            end else begin
              o_tx_done <= 1'b1;
              state_r   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          o_tx_done <= 1'b0;
          o_busy    <= 1'b0;
          o_tx      <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: begin
          o_tx_done <= 1'b0;
          o_busy    <= 1'b0;
          o_tx      <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
